// File: rtl/result_tx_buffer_pkg.sv
// Shared definitions for the result transmit buffer.
//   DEFAULT_NB_DATA : default width of one result byte
//   DEFAULT_TIMEOUT : default per-frame watchdog limit, in clock cycles
//   tx_state_e      : frame sequencer states
package result_tx_buffer_pkg;

   localparam int DEFAULT_NB_DATA = 8;
   localparam int DEFAULT_TIMEOUT = 20000;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2
   } tx_state_e;

endpackage

// File: rtl/result_tx_buffer_sync_fifo.sv
// Synchronous FIFO holding results waiting for the UART.
// Ports:
//   i_clock, i_reset : rising-edge clock, synchronous active-high reset
//   i_push, i_push_data : write strobe and data
//   i_pop            : remove the head entry
//   o_head           : head entry (0 while empty)
//   o_count          : occupancy 0..DEPTH
//   o_full, o_empty  : occupancy flags
//   o_overflow       : sticky, a push was dropped because the FIFO was full
module sync_fifo #(
   parameter int NB_DATA = 8,
   parameter int DEPTH   = 4,
   parameter int NB_ADDR = $clog2(DEPTH)
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_push,
   input  logic [NB_DATA-1:0] i_push_data,
   input  logic               i_pop,
   output logic [NB_DATA-1:0] o_head,
   output logic [NB_ADDR:0]   o_count,
   output logic               o_full,
   output logic               o_empty,
   output logic               o_overflow
);

   logic [NB_DATA-1:0] mem [DEPTH];
   logic [NB_ADDR-1:0] wr_ptr;
   logic [NB_ADDR-1:0] rd_ptr;
   logic [NB_ADDR:0]   count;
   logic               overflow;
   logic               push_ok;
   logic               pop_ok;

   assign o_full  = (count == (NB_ADDR+1)'(DEPTH));
   assign o_empty = (count == '0);

   // A pop in the same cycle frees the slot, so a push into a full FIFO
   // is still accepted then.
   assign pop_ok  = i_pop && !o_empty;
   assign push_ok = i_push && (!o_full || pop_ok);

   // Storage is deliberately left out of reset.
   always_ff @(posedge i_clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + NB_ADDR'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + NB_ADDR'(1);
         if (push_ok && !pop_ok) begin
            count <= count + (NB_ADDR+1)'(1);
         end else if (!push_ok && pop_ok) begin
            count <= count - (NB_ADDR+1)'(1);
         end
         if (i_push && !push_ok) overflow <= 1'b1;
      end
   end

   assign o_head     = o_empty ? '0 : mem[rd_ptr];
   assign o_count    = count;
   assign o_overflow = overflow;

endmodule

// File: rtl/result_tx_buffer.sv
// Buffers ALU results and feeds them one frame at a time to the UART TX.
// Ports:
//   i_clock, i_reset   : rising-edge clock, synchronous active-high reset
//   i_result_data/valid: result byte and its one-cycle push strobe
//   i_tx_done          : end-of-frame pulse from the UART TX
//   o_tx_data          : byte presented to the UART TX (FIFO head)
//   o_tx_start         : one-cycle frame-start strobe
//   o_count            : FIFO occupancy
//   o_full, o_empty    : occupancy flags
//   o_overflow         : sticky, a result was dropped
//   o_timeout          : sticky, a frame was abandoned by the watchdog
module result_tx_buffer
   import result_tx_buffer_pkg::*;
#(
   parameter int NB_DATA    = DEFAULT_NB_DATA,
   parameter int DEPTH      = 4,
   parameter int NB_ADDR    = $clog2(DEPTH),
   parameter int TIMEOUT    = DEFAULT_TIMEOUT,
   parameter int NB_TIMEOUT = $clog2(TIMEOUT+1)
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_result_data,
   input  logic               i_result_valid,
   input  logic               i_tx_done,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic [NB_ADDR:0]   o_count,
   output logic               o_full,
   output logic               o_empty,
   output logic               o_overflow,
   output logic               o_timeout
);

   tx_state_e             state;
   tx_state_e             state_next;
   logic [NB_TIMEOUT-1:0] wd;
   logic [NB_TIMEOUT-1:0] wd_next;
   logic                  pop;
   logic                  timeout_hit;
   logic                  timeout_flag;

   sync_fifo #(
      .NB_DATA (NB_DATA),
      .DEPTH   (DEPTH),
      .NB_ADDR (NB_ADDR)
   ) u_fifo (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_push      (i_result_valid),
      .i_push_data (i_result_data),
      .i_pop       (pop),
      .o_head      (o_tx_data),
      .o_count     (o_count),
      .o_full      (o_full),
      .o_empty     (o_empty),
      .o_overflow  (o_overflow)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state        <= IDLE;
         wd           <= '0;
         timeout_flag <= 1'b0;
      end else begin
         state <= state_next;
         wd    <= wd_next;
         if (timeout_hit) timeout_flag <= 1'b1;
      end
   end

   // The START cycle counts as the first cycle of the frame, so the watchdog
   // (counting WAIT_DONE cycles from 0) fires at TIMEOUT-2: the abandon then
   // lands exactly TIMEOUT cycles after o_tx_start.
   always_comb begin
      state_next  = state;
      wd_next     = wd;
      pop         = 1'b0;
      timeout_hit = 1'b0;
      o_tx_start  = 1'b0;
      case (state)
         IDLE: begin
            if (!o_empty) state_next = START;
         end
         START: begin
            o_tx_start = 1'b1;
            wd_next    = '0;
            state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (i_tx_done) begin
               pop        = 1'b1;
               state_next = IDLE;
            end else if (wd == NB_TIMEOUT'(TIMEOUT-2)) begin
               pop         = 1'b1;
               timeout_hit = 1'b1;
               state_next  = IDLE;
            end else begin
               wd_next = wd + NB_TIMEOUT'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign o_timeout = timeout_flag;

endmodule
